core_dram_arbiter: RTL and testbench
====================================

Name: core_dram_arbiter

Overview:
- Round-robin arbiter sharing the single data RAM port among N_CORES processor cores.
- Each core presents a request carrying address, write data and write enable; the arbiter serialises them onto the RAM port.
- It returns a one-cycle acknowledge to the winning core, with read data for reads.
- Sits between the core array and the shared DRAM block in the multi-core top level.

Parameters:
- N_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LAT, 1, RAM read latency in clk cycles from address capture to valid q (1..4)

Ports:
- clk  in  1  fast clock (all logic on rising edge)
- rst_n  in  1  synchronous reset, active low
- req  in  N_CORES  per-core request, held until ack
- wren  in  N_CORES  per-core write enable (1 = write, 0 = read), valid with req
- addr  in  N_CORES*ADDR_W  packed per-core address, core i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  N_CORES*DATA_W  packed per-core write data
- ack  out  N_CORES  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while ack is high for a read
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  DATA_W  RAM read data
- busy  out  1  high in any state other than IDLE
- owner  out  3  index of the current or last granted core

Behaviour:
- Reset: while rst_n = 0 at a rising edge:
  - state <= IDLE, rr_ptr <= 0, latency counter <= 0
  - ack = 0, rdata = 0, mem_addr = 0, mem_wdata = 0, mem_wren = 0, busy = 0, owner = 0
  - Reset mid-transaction abandons it: no ack is issued and mem_wren drops at the reset edge.
- States: IDLE, ACCESS, DONE.
- IDLE, edge E0, req != 0:
  - Winner = first set req bit searching from rr_ptr upward, wrapping modulo N_CORES.
  - Load mem_addr, mem_wdata and mem_wren from the winner's slice; owner <= winner.
  - state <= ACCESS, counter <= 0.
  - With req = 0: hold; mem_wren = 0.
- ACCESS, write (latched wren = 1):
  - mem_wren is high for exactly the one cycle following E0.
  - At E1: mem_wren <= 0, ack[owner] <= 1, rr_ptr <= (owner+1) mod N_CORES, state <= DONE.
- ACCESS, read:
  - mem_wren stays 0; mem_addr is held.
  - Counter increments each edge; at edge E(1+RD_LAT): rdata <= mem_q, ack[owner] <= 1, rr_ptr advances, state <= DONE.
- DONE (exactly one cycle):
  - ack high, rdata stable.
  - At the next edge: ack <= 0, state <= IDLE.
  - req is not sampled in DONE; the acked core must drop req by that edge.
- Latency from req sampled to ack high:
  - write: 1 cycle
  - read: 1+RD_LAT cycles
  - Minimum turnaround between grants: write 3 cycles, read 3+RD_LAT cycles.
- Other request and data rules:
  - Losing requests are held untouched; no starvation, since any waiting core is served within N_CORES grants.
  - A request deasserted after being granted still completes and is still acked.
  - Changes to addr, wdata or wren after the grant edge are ignored.
  - rdata holds its last read value after ack drops; writes do not modify rdata.
- mem_addr and mem_wdata hold their last values in IDLE and DONE.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority; winner is always the lowest-index set req bit; rr_ptr is removed (owner still reported).
- Undefined (default): round-robin as above.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with req = 4'b1111 -> ack = 0, mem_wren = 0, busy = 0, owner = 0; release with req = 0 -> stays IDLE.
- Single write: core 2 req, wren = 1, addr = 16'h0040, wdata = 16'hBEEF -> the next cycle has mem_wren = 1, mem_addr = 16'h0040, mem_wdata = 16'hBEEF; the cycle after has ack = 4'b0100 for one cycle.
- Single read, RD_LAT = 2: core 1 reads addr 16'h0040 while the RAM model returns 16'hBEEF -> ack = 4'b0010 three cycles after the req edge, rdata = 16'hBEEF, mem_wren never high.
- Round-robin: all four cores request reads continuously -> grant order 0, 1, 2, 3, 0; owner follows; each ack is one-hot and one cycle wide.
- Requester withdrawal: core 3 drops req the cycle after its grant -> ack[3] still pulses; a core 0 request pending during DONE is granted only after IDLE is re-entered.
- Reset mid-read: assert rst_n = 0 during ACCESS -> no ack pulse; state IDLE; rr_ptr = 0, so the next grant with req = 4'b1010 goes to core 1.

Source files
------------

// File: rtl/core_dram_arbiter_if.sv
// Core-array / shared data RAM bus bundle for core_dram_arbiter.
// slave: the arbiter side; master: the cores plus the RAM.
interface core_dram_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        wren;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_wren;
  logic [DATA_W-1:0]         mem_q;
  logic                      busy;
  logic [2:0]                owner;

  modport slave (
    input  req, wren, addr, wdata, mem_q,
    output ack, rdata, mem_addr, mem_wdata, mem_wren, busy, owner
  );

  modport master (
    output req, wren, addr, wdata, mem_q,
    input  ack, rdata, mem_addr, mem_wdata, mem_wren, busy, owner
  );
endinterface

// File: rtl/core_dram_arbiter.sv
// Arbiter serialising N_CORES core requests onto the single data RAM port.
// One transaction at a time: IDLE -> ACCESS -> DONE (one-cycle ack).
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of
// round-robin.
module core_dram_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input logic                clk,
  input logic                rst_n,
  core_dram_arbiter_if.slave bus
);
  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                          state;
  logic [IDX_W-1:0]                own_idx, win;
  logic [2:0]                      cnt;
  logic                            is_wr;
  logic [N_CORES-1:0]              ack_q;
  logic [DATA_W-1:0]               rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]               mem_addr_q;
  logic                            mem_wren_q;
  logic [N_CORES-1:0][ADDR_W-1:0]  addr_a;
  logic [N_CORES-1:0][DATA_W-1:0]  wdata_a;

  // packed bus slices line up with core i at [i*W +: W]
  assign addr_a  = bus.addr;
  assign wdata_a = bus.wdata;

`ifdef ARB_FIXED_PRIO_EN
  // winner is the lowest-index requester
  always_comb begin
    win = '0;
    for (int k = N_CORES-1; k >= 0; k--)
      if (bus.req[k]) win = IDX_W'(k);
  end
`else
  logic [IDX_W-1:0] rr_ptr, nxt_idx, idx;
  int               s;

  assign nxt_idx = (own_idx == IDX_W'(N_CORES-1)) ? '0 : own_idx + 1'b1;

  // winner is the first requester at or above rr_ptr, wrapping; scanning
  // downward lets the closest candidate overwrite the farther ones
  always_comb begin
    win = rr_ptr;
    s   = 0;
    idx = '0;
    for (int k = N_CORES-1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      if (s >= N_CORES) s = s - N_CORES;
      idx = IDX_W'(s);
      if (bus.req[idx]) win = idx;
    end
  end
`endif

  // transaction FSM; all outputs registered, request fields latched at grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      own_idx     <= '0;
      cnt         <= '0;
      is_wr       <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            mem_addr_q  <= addr_a[win];
            mem_wdata_q <= wdata_a[win];
            mem_wren_q  <= bus.wren[win];
            is_wr       <= bus.wren[win];
            own_idx     <= win;
            cnt         <= '0;
            state       <= ACCESS;
          end else begin
            mem_wren_q  <= 1'b0;
          end
        end
        ACCESS: begin
          // writes finish after their single strobe cycle; reads wait RD_LAT
          if (is_wr || cnt == 3'(RD_LAT)) begin
            mem_wren_q <= 1'b0;
            ack_q      <= N_CORES'(1) << own_idx;
            if (!is_wr) rdata_q <= bus.mem_q;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr     <= nxt_idx;
`endif
            state      <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          ack_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.busy      = (state != IDLE);
  assign bus.owner     = 3'(own_idx);
endmodule

// File: tb/tb_core_dram_arbiter.sv
// Scoreboard bench for core_dram_arbiter: a transaction-level model predicts
// grants, ack timing and read data; a negedge monitor compares.
module tb_core_dram_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 2;

  typedef struct {
    int           core;
    bit           rd;
    logic [DW-1:0] data;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_dram_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  core_dram_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // RAM: q is the word addressed RL edges earlier
  logic [DW-1:0] ram   [16] = '{default: '0};
  logic [DW-1:0] rpipe [RL] = '{default: '0};
  assign bus.mem_q = rpipe[RL-1];

  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
    rpipe[0] <= ram[bus.mem_addr[3:0]];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end

  // reference model state
  int            cyc = 0;
  bit            m_busy = 0, m_done = 0, m_rd = 0, m_wren = 0;
  int            m_left = 0, m_rr = 0, m_owner = 0, m_gcyc = 0, w = 0;
  logic [N-1:0]  m_ack = '0;
  logic [DW-1:0] m_rdata = '0, m_rval = '0, m_d = '0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] ref_mem [int];
  exp_t          sb [$];

  int   n_chk = 0, n_pass = 0;
  bit   end_req = 0, end_ack = 0;
  logic [N-1:0] outst = '0;
  int   p_new = 0, p_wr = 0, p_wd = 0;

  function automatic int pick(logic [N-1:0] r, int ptr);
    int st;
    st = ptr;
`ifdef ARB_FIXED_PRIO_EN
    st = 0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(st + k) % N]) return (st + k) % N;
    return 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // model: one grant at a time, ack after 1 (write) or 1+RL (read) edges,
  // one ack cycle, then idle again before the next grant
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_left = 0; m_rr = 0; m_owner = 0;
        m_wren = 0; m_ack = '0; m_rdata = '0;
        sb.delete();
      end else if (m_done) begin
        m_done = 0; m_busy = 0; m_ack = '0;
      end else if (m_busy) begin
        m_wren = 0;
        m_left--;
        if (m_left == 0) begin
          m_ack  = N'(1) << m_owner;
          m_done = 1;
          if (m_rd) m_rdata = m_rval;
          m_rr = (m_owner + 1) % N;
        end
      end else if (bus.req != '0) begin
        w       = pick(bus.req, m_rr);
        m_busy  = 1;
        m_owner = w;
        m_gcyc  = cyc;
        m_rd    = !bus.wren[w];
        m_a     = bus.addr[w*AW +: AW];
        m_d     = bus.wdata[w*DW +: DW];
        m_left  = m_rd ? 1 + RL : 1;
        m_wren  = !m_rd;
        if (m_rd) m_rval = ref_mem.exists(int'(m_a)) ? ref_mem[int'(m_a)] : '0;
        else ref_mem[int'(m_a)] = m_d;
        sb.push_back('{w, m_rd, m_rd ? m_rval : '0, cyc + m_left});
      end else begin
        m_wren = 0;
      end
    end
  end

  // monitor: per-cycle output state plus scoreboard pop on every ack
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("ack",      32'(bus.ack),      32'(m_ack));
      chk("busy",     32'(bus.busy),     32'(m_busy));
      chk("mem_wren", 32'(bus.mem_wren), 32'(m_wren));
      chk("owner",    32'(bus.owner),    32'(m_owner));
      chk("rdata",    32'(bus.rdata),    32'(m_rdata));
      if (m_wren) begin
        chk("mem_addr",  32'(bus.mem_addr),  32'(m_a));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_d));
      end
      if (bus.ack != '0) begin
        chk("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ack_core",  32'(bus.ack), 32'(N'(1) << e.core));
          chk("ack_cycle", 32'(cyc),     32'(e.cyc));
          if (e.rd) chk("rd_data", 32'(bus.rdata), 32'(e.data));
        end
      end
      if (end_req && !end_ack) begin
        chk("drain_sb",    32'(sb.size()), 32'd0);
        chk("drain_cores", 32'(outst),     32'd0);
        end_ack = 1;
      end
    end
  end

  task automatic issue(int i, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.wren[i]          = wr;
    bus.addr[i*AW +: AW] = a;
    bus.wdata[i*DW +: DW] = d;
    bus.req[i]           = 1'b1;
    outst[i]             = 1'b1;
  endtask

  // one cycle of core behaviour: drop on ack, maybe request, maybe withdraw
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.ack[i]) begin
        bus.req[i] = 1'b0;
        outst[i]   = 1'b0;
      end else if (!outst[i] && int'($urandom_range(99)) < p_new) begin
        issue(i, int'($urandom_range(99)) < p_wr, 16'h0040 + AW'($urandom_range(15)), DW'($urandom));
      end
    end
    if (p_wd > 0 && m_busy && !m_done && cyc == m_gcyc && bus.req[m_owner] &&
        int'($urandom_range(99)) < p_wd) begin
      bus.req[m_owner]  = 1'b0;
      bus.wren[m_owner] = ~bus.wren[m_owner];
      bus.addr[m_owner*AW +: AW]  = AW'($urandom);
      bus.wdata[m_owner*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic steps(int n);
    for (int t = 0; t < n; t++) step();
  endtask

  initial begin
    bus.req = '1; bus.wren = '0; bus.addr = '0; bus.wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.req = '0;
    rst_n = 1'b1;
    steps(3);

    // single write, then a read of the same word
    issue(2, 1'b1, 16'h0040, 16'hBEEF);
    steps(6);
    issue(1, 1'b0, 16'h0040, 16'h0000);
    steps(8);

    // all cores reading continuously from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    p_new = 100; p_wr = 0;
    steps(40);
    p_new = 0;
    steps(20);

    // core 3 withdraws after grant; core 0 arrives during DONE
    issue(3, 1'b0, 16'h0041, 16'h0000);
    step();
    bus.req[3] = 1'b0;
    bus.wren[3] = 1'b1;
    bus.addr[3*AW +: AW] = 16'h0047;
    for (int t = 0; t < 20 && outst[3]; t++) step();
    issue(0, 1'b1, 16'h0042, 16'h1234);
    steps(10);

    // reset in the middle of a read abandons it and clears the pointer
    issue(2, 1'b0, 16'h0040, 16'h0000);
    steps(2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req = '0;
    outst = '0;
    issue(1, 1'b0, 16'h0043, 16'h0000);
    issue(3, 1'b0, 16'h0044, 16'h0000);
    steps(20);

    // randomized traffic with withdrawals and post-grant field changes
    p_new = 30; p_wr = 50; p_wd = 25;
    steps(800);
    p_new = 0; p_wd = 0;
    steps(60);

    end_req = 1;
    for (int t = 0; t < 4 && !end_ack; t++) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
